// File: rtl/uart_tx_buf.sv
// uart_tx_buf: buffered 8N1 UART transmitter.
// A host write port pushes bytes into a circular FIFO; a serializer drains
// the FIFO onto tx_o, LSB first, one bit every CLK_DIV clocks. Frames are
// sent back to back with no idle gap while the FIFO has data.
//
// Ports:
//   clk_i              single clock for the whole block
//   rst_ni             asynchronous active-low reset, clears all state
//   wr_en_i, din_i     write strobe and byte to enqueue
//   full_o, empty_o    FIFO holds 2**ADDR_W / 0 bytes
//   count_o            number of bytes stored
//   overflow_o         one-cycle pulse after a dropped write
//   tx_o               serial line, idles high, driven from a flop
//   is_transmitting_o  high while a frame is on the line
module uart_tx_buf #(
    parameter int CLK_DIV = 434,
    parameter int ADDR_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [7:0]        din_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic              tx_o,
    output logic              is_transmitting_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);

    // state   | meaning
    // S_IDLE  | line high, waiting for a byte in the FIFO
    // S_START | start bit (low) for CLK_DIV cycles
    // S_DATA  | data bits 0..7, LSB first
    // S_STOP  | stop bit (high); chains straight into S_START if more data
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]       mem_q [DEPTH];
    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]  count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             push, pop, baud_end;

    // count never exceeds DEPTH, so its MSB alone marks full.
    assign full_o            = count_q[ADDR_W];
    assign empty_o           = (count_q == '0);
    assign count_o           = count_q;
    assign overflow_o        = overflow_q;
    assign tx_o              = tx_q;
    assign is_transmitting_o = (state_q != S_IDLE);

    // Full is judged before any same-edge pop, so a write to a full FIFO
    // is always dropped.
    assign push       = wr_en_i && !full_o;
    assign overflow_d = wr_en_i && full_o;
    assign baud_end   = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!empty_o) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!empty_o) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= din_i;
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
module tb_uart_tx_buf;

    localparam int CLK_DIV = 4;
    localparam int ADDR_W  = 2;
    localparam int FRAME   = 10 * CLK_DIV;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [7:0]        din;
    logic              full, empty, overflow, tx, busy;
    logic [ADDR_W:0]   count;

    int n_checks = 0;
    int n_errs   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] wrap_bytes [40];

    uart_tx_buf #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .wr_en_i           (wr_en),
        .din_i             (din),
        .full_o            (full),
        .empty_o           (empty),
        .count_o           (count),
        .overflow_o        (overflow),
        .tx_o              (tx),
        .is_transmitting_o (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level c cycles after the first start edge for a run of
    // frames taken from exp_q: start 0, data LSB first, stop 1.
    function automatic logic line_bit(input int c);
        int f;
        int bi;
        logic [7:0] b;
        f  = c / FRAME;
        bi = (c % FRAME) / CLK_DIV;
        b  = exp_q[f];
        if (bi == 0) return 1'b0;
        if (bi == 9) return 1'b1;
        return b[bi-1];
    endfunction

    // Called at the negedge that is cycle c0 of the first frame.
    task automatic check_stream(input int n, input int c0);
        for (int c = c0; c < n * FRAME; c++) begin
            check_eq("frame_tx", tx, line_bit(c));
            check_eq("frame_busy", busy, 1);
            @(negedge clk);
        end
        check_eq("end_busy", busy, 0);
        check_eq("end_tx", tx, 1);
        check_eq("end_empty", empty, 1);
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check_eq(tag, tx, 1);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        din   = 8'h00;

        // Reset then idle
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_full", full, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_count", count, 0);
        check_eq("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check_eq("idle_tx", tx, 1);
            check_eq("idle_empty", empty, 1);
            check_eq("idle_count", count, 0);
            check_eq("idle_busy", busy, 0);
        end

        // Single byte 0xA5
        exp_q.delete();
        exp_q.push_back(8'hA5);
        wr_en = 1'b1; din = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        check_eq("lat_tx_e0", tx, 1);
        check_eq("lat_empty_e0", empty, 0);
        check_eq("lat_count_e0", count, 1);
        @(negedge clk);
        check_eq("lat_tx_e1", tx, 0);
        check_eq("lat_busy_e1", busy, 1);
        check_stream(1, 0);
        check_idle("post_single_idle", 10);

        // Back-to-back 0x00, 0xFF, 0x3C
        exp_q.delete();
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h3C);
        wr_en = 1'b1; din = 8'h00;
        @(negedge clk); din = 8'hFF;
        @(negedge clk); din = 8'h3C;
        check_eq("b2b_start", tx, 0);
        @(negedge clk);
        wr_en = 1'b0;
        check_stream(3, 1);
        check_idle("post_b2b_idle", 10);

        // Full and overflow: six writes, depth 4, first one popped at once
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            din = 8'($urandom);
            if (i < 5) exp_q.push_back(din);
            wr_en = 1'b1;
            @(negedge clk);
            if (i == 4) begin
                check_eq("full_count", count, 4);
                check_eq("full_flag", full, 1);
                check_eq("full_ovf_pre", overflow, 0);
            end
        end
        wr_en = 1'b0;
        check_eq("ovf_pulse", overflow, 1);
        check_eq("ovf_count", count, 4);
        @(negedge clk);
        check_eq("ovf_clear", overflow, 0);
        check_stream(5, 5);
        check_idle("only5_idle", 60);

        // Pointer wrap: 40 random bytes slightly slower than the line rate
        begin
            bit rd_done = 1'b0;
            int max_cnt = 0;
            bit ovf_seen = 1'b0;
            for (int i = 0; i < 40; i++) wrap_bytes[i] = 8'($urandom);
            fork
                begin
                    for (int i = 0; i < 40; i++) begin
                        wr_en = 1'b1; din = wrap_bytes[i];
                        @(negedge clk);
                        wr_en = 1'b0;
                        repeat ($urandom_range(FRAME + 3, FRAME) ) @(negedge clk);
                    end
                end
                begin
                    for (int i = 0; i < 40; i++) begin
                        int waited = 0;
                        logic [7:0] b;
                        while (tx !== 1'b0 && waited < 300) begin
                            @(negedge clk);
                            waited++;
                        end
                        if (tx !== 1'b0) begin
                            check_eq("wrap_start_timeout", tx, 0);
                            break;
                        end
                        repeat (CLK_DIV / 2) @(negedge clk);
                        check_eq("wrap_startbit", tx, 0);
                        for (int k = 0; k < 8; k++) begin
                            repeat (CLK_DIV) @(negedge clk);
                            b[k] = tx;
                        end
                        repeat (CLK_DIV) @(negedge clk);
                        check_eq("wrap_stopbit", tx, 1);
                        check_eq("wrap_byte", b, wrap_bytes[i]);
                        repeat (CLK_DIV / 2) @(negedge clk);
                    end
                    rd_done = 1'b1;
                end
                begin
                    while (!rd_done) begin
                        if (int'(count) > max_cnt) max_cnt = int'(count);
                        if (overflow) ovf_seen = 1'b1;
                        @(negedge clk);
                    end
                end
            join
            check_eq("wrap_count_le4", (max_cnt <= 4), 1);
            check_eq("wrap_no_ovf", ovf_seen, 0);
        end
        check_idle("post_wrap_idle", 20);
        check_eq("post_wrap_empty", empty, 1);

        // Reset mid-frame during data bit 3 with two bytes queued
        wr_en = 1'b1; din = 8'h5A;
        @(negedge clk); din = 8'hC3;
        @(negedge clk); din = 8'h81;
        @(negedge clk);
        wr_en = 1'b0;
        check_eq("mid_count", count, 2);
        repeat (16) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_tx", tx, 1);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_empty", empty, 1);
        check_eq("mid_rst_count", count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check_eq("mid_post_tx", tx, 1);
            check_eq("mid_post_empty", empty, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
